countone_deadlock_reporter: RTL and testbench

Consumer side of the HLS deadlock monitor output. It watches the monitor's `block` / `axis_block_info` pair and qualifies a deadlock only when `block` stays high for `HOLD_CYCLES` consecutive cycles. On qualification it latches the blocking-channel info and a timestamp, then sends a two-word report on an AXI-Stream-style master port. It sits between the `countone` deadlock monitor and the PS-side debug capture path.

---
 rtl/countone_deadlock_reporter_if.sv | 9 +
 rtl/countone_deadlock_reporter.sv | 74 +++++++
 tb/tb_countone_deadlock_reporter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/countone_deadlock_reporter_if.sv
// countone_deadlock_reporter_if: stream port carrying the two-word deadlock report.
interface countone_deadlock_reporter_if;
    logic [31:0] tdata;
    logic tvalid;
    logic tready;
    logic tlast;
    modport master(output tdata, tvalid, tlast, input tready);
    modport slave(input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/countone_deadlock_reporter.sv
// countone_deadlock_reporter: qualifies a sustained monitor block, then sends {tag, count, info} and timestamp words.
module countone_deadlock_reporter #(
    parameter int INFO_W = 9,
    parameter int HOLD_CYCLES = 16,
    parameter int TS_W = 32
) (
    input  logic clock,
    input  logic reset,
    input  logic block,
    input  logic [INFO_W-1:0] axis_block_info,
    input  logic clear,
    countone_deadlock_reporter_if.master report,
    output logic deadlock_flag,
    output logic [7:0] report_count
);
    localparam int HC_W = $clog2(HOLD_CYCLES) + 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
    typedef enum logic [2:0] {IDLE, QUALIFY, SEND0, SEND1, LATCHED} state_t;
    state_t state;
    logic [TS_W-1:0] ts;
    logic [TS_W-1:0] ts_cap;
    logic [INFO_W-1:0] info_cap;
    logic [HC_W-1:0] hold_cnt;
    // Stream outputs decode from state and captured registers only, never from inputs.
    assign report.tvalid = state == SEND0 || state == SEND1;
    assign report.tlast = state == SEND1;
    assign report.tdata = state == SEND0 ? {8'hDE, report_count, 7'b0, 9'(info_cap)} :
                          state == SEND1 ? 32'(ts_cap) : 32'b0;
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            ts <= '0;
            ts_cap <= '0;
            info_cap <= '0;
            hold_cnt <= '0;
            deadlock_flag <= 1'b0;
            report_count <= 8'd0;
        end else begin
            ts <= ts + 1'b1;
            case (state)
                IDLE: if (block) begin
                    ts_cap <= ts;
                    hold_cnt <= HC_W'(1);
                    if (HOLD_CYCLES == 1) begin
                        info_cap <= axis_block_info;
                        deadlock_flag <= 1'b1;
                        state <= SEND0;
                    end else begin
                        state <= QUALIFY;
                    end
                end
                QUALIFY: if (!block) begin
                    state <= IDLE;
                end else if (hold_cnt == HOLD_LAST) begin
                    info_cap <= axis_block_info;
                    deadlock_flag <= 1'b1;
                    state <= SEND0;
                end else begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
                SEND0: if (report.tready) state <= SEND1;
                SEND1: if (report.tready) begin
                    state <= LATCHED;
                    if (report_count != 8'hFF) report_count <= report_count + 1'b1;
                end
                LATCHED: if (clear) begin
                    deadlock_flag <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_countone_deadlock_reporter.sv
// tb_countone_deadlock_reporter: directed checks on a HOLD_CYCLES=16 instance and a HOLD_CYCLES=1, TS_W=4 instance.
module tb_countone_deadlock_reporter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic block_a = 1'b0, clear_a = 1'b0, block_b = 1'b0, clear_b = 1'b0;
    logic [8:0] info_a = 9'h0, info_b = 9'h0;
    logic flag_a, flag_b;
    logic [7:0] cnt_a, cnt_b;
    logic [7:0] cnt_exp;
    logic [3:0] ts_exp;
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    countone_deadlock_reporter_if rep_a();
    countone_deadlock_reporter_if rep_b();

    countone_deadlock_reporter #(.INFO_W(9), .HOLD_CYCLES(16), .TS_W(32)) dut_a (
        .clock(clock), .reset(reset), .block(block_a), .axis_block_info(info_a),
        .clear(clear_a), .report(rep_a), .deadlock_flag(flag_a), .report_count(cnt_a));

    countone_deadlock_reporter #(.INFO_W(9), .HOLD_CYCLES(1), .TS_W(4)) dut_b (
        .clock(clock), .reset(reset), .block(block_b), .axis_block_info(info_b),
        .clear(clear_b), .report(rep_b), .deadlock_flag(flag_b), .report_count(cnt_b));

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rep_a.tready = 1'b0;
        rep_b.tready = 1'b0;
        do_reset();
        chk("rst_a_tvalid", rep_a.tvalid, 0);
        chk("rst_a_tlast", rep_a.tlast, 0);
        chk("rst_a_tdata", rep_a.tdata, 0);
        chk("rst_a_flag", flag_a, 0);
        chk("rst_a_count", cnt_a, 0);
        chk("rst_b_tvalid", rep_b.tvalid, 0);
        chk("rst_b_flag", flag_b, 0);
        chk("rst_b_count", cnt_b, 0);

        // Clean qualification: block from ts=10, info sampled in cycle 25.
        while (cyc < 10) tick();
        block_a = 1'b1;
        rep_a.tready = 1'b1;
        info_a = 9'h0AA;
        while (cyc < 25) tick();
        chk("qual_pre_tvalid", rep_a.tvalid, 0);
        chk("qual_pre_flag", flag_a, 0);
        info_a = 9'h1FD;
        tick();
        chk("word0_tvalid", rep_a.tvalid, 1);
        chk("word0_flag", flag_a, 1);
        chk("word0_tdata", rep_a.tdata, 32'hDE0001FD);
        chk("word0_tlast", rep_a.tlast, 0);
        block_a = 1'b0;
        tick();
        chk("word1_tvalid", rep_a.tvalid, 1);
        chk("word1_tdata", rep_a.tdata, 32'h0000000A);
        chk("word1_tlast", rep_a.tlast, 1);
        clear_a = 1'b1;
        tick();
        clear_a = 1'b0;
        chk("count_after_1", cnt_a, 1);
        chk("latched_tvalid", rep_a.tvalid, 0);
        chk("latched_flag", flag_a, 1);
        tick();
        chk("latched_hold_flag", flag_a, 1);
        clear_a = 1'b1;
        tick();
        clear_a = 1'b0;
        chk("clear_flag", flag_a, 0);
        chk("clear_count", cnt_a, 1);

        // Glitch: 15 cycles of block must not qualify.
        block_a = 1'b1;
        repeat (15) tick();
        block_a = 1'b0;
        chk("glitch_tvalid_45", rep_a.tvalid, 0);
        while (cyc < 50) tick();
        chk("glitch_tvalid", rep_a.tvalid, 0);
        chk("glitch_flag", flag_a, 0);

        // Second qualification with backpressure.
        block_a = 1'b1;
        info_a = 9'h003;
        rep_a.tready = 1'b0;
        while (cyc < 65) tick();
        chk("requal_early_tvalid", rep_a.tvalid, 0);
        tick();
        chk("requal_tvalid", rep_a.tvalid, 1);
        chk("requal_word0", rep_a.tdata, 32'hDE010003);
        block_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_word0", rep_a.tdata, 32'hDE010003);
            chk("stall_tvalid", rep_a.tvalid, 1);
            chk("stall_tlast", rep_a.tlast, 0);
        end
        rep_a.tready = 1'b1;
        tick();
        chk("bp_word1", rep_a.tdata, 32'h00000032);
        chk("bp_word1_tlast", rep_a.tlast, 1);
        tick();
        chk("bp_count", cnt_a, 2);
        chk("bp_no_dup", rep_a.tvalid, 0);
        clear_a = 1'b1;
        tick();
        clear_a = 1'b0;
        chk("bp_clear_flag", flag_a, 0);

        // Reset in the middle of a stalled SEND0.
        block_a = 1'b1;
        rep_a.tready = 1'b0;
        while (cyc < 90) tick();
        chk("stall3_tvalid", rep_a.tvalid, 1);
        chk("stall3_word0", rep_a.tdata, 32'hDE020003);
        block_a = 1'b0;
        do_reset();
        chk("midrst_tvalid", rep_a.tvalid, 0);
        chk("midrst_count", cnt_a, 0);
        chk("midrst_flag", flag_a, 0);
        chk("midrst_ts", dut_a.ts, 0);
        chk("midrst_tdata", rep_a.tdata, 0);

        // HOLD_CYCLES=1: single-cycle pulse.
        while (cyc < 2) tick();
        chk("h1_idle_tvalid", rep_b.tvalid, 0);
        block_b = 1'b1;
        info_b = 9'h155;
        tick();
        block_b = 1'b0;
        chk("h1_tvalid", rep_b.tvalid, 1);
        chk("h1_word0", rep_b.tdata, 32'hDE000155);
        chk("h1_flag", flag_b, 1);
        rep_b.tready = 1'b1;
        tick();
        chk("h1_word1", rep_b.tdata, 32'h00000002);
        chk("h1_tlast", rep_b.tlast, 1);
        tick();
        chk("h1_count", cnt_b, 1);
        clear_b = 1'b1;
        tick();
        clear_b = 1'b0;

        // 4-bit timestamp wrap.
        while (cyc < 15) tick();
        chk("ts_top", dut_b.ts, 32'hF);
        tick();
        chk("ts_wrap", dut_b.ts, 0);

        // Saturation: 256 more reports, count byte in word0 must stop at 255.
        for (int i = 1; i < 257; i++) begin
            cnt_exp = (i > 255) ? 8'hFF : 8'(i);
            ts_exp = cyc[3:0];
            block_b = 1'b1;
            tick();
            block_b = 1'b0;
            chk("sat_word0", rep_b.tdata, {8'hDE, cnt_exp, 16'h0155});
            tick();
            chk("sat_word1", rep_b.tdata, 32'(ts_exp));
            tick();
            clear_b = 1'b1;
            tick();
            clear_b = 1'b0;
        end
        chk("sat_count", cnt_b, 255);
        chk("sat_flag", flag_b, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
